// File: rtl/ahb_tb_pkg.sv
// Shared AHB-Lite types and helpers for the testbench-side request master.
package ahb_tb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        SIZE_BYTE  = 3'd0,
        SIZE_HALF  = 3'd1,
        SIZE_WORD  = 3'd2,
        SIZE_DWORD = 3'd3
    } hsize_e;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef struct packed {
        logic        write;
        logic [63:0] rdata;
        logic        err;
    } ahb_rsp_t;

    function automatic logic addr_aligned(input logic [31:0] addr, input logic [2:0] size);
        case (size)
            3'd0:    return 1'b1;
            3'd1:    return addr[0] == 1'b0;
            3'd2:    return addr[1:0] == 2'b00;
            3'd3:    return addr[2:0] == 3'b000;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_rsp_fifo.sv
// First-word-fall-through response FIFO; head is valid whenever count is non-zero.
module ahb_rsp_fifo
    import ahb_tb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  ahb_rsp_t      push_data,
    input  logic          pop,
    output ahb_rsp_t      head_data,
    output logic [CW-1:0] count
);

    ahb_rsp_t      mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Storage carries no reset; consumers qualify the head with count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

    assert property (@(posedge clk) disable iff (rst) !(push && !pop && count_q == CW'(DEPTH)));
    assert property (@(posedge clk) disable iff (rst) !(pop && count_q == '0));

endmodule

// File: rtl/ahb_lite_req_master.sv
// Valid/ready request stream to pipelined single AHB-Lite transfers, with in-order responses.
module ahb_lite_req_master
    import ahb_tb_pkg::*;
#(
    parameter int RSP_DEPTH = 4
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [3:0]  req_prot,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_write,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] HADDR,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [3:0]  HPROT,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HBURST,
    output logic [63:0] HWDATA,
    output logic        HSEL,
    input  logic        HREADY,
    input  logic        HRESP,
    input  logic [63:0] HRDATA
);

    localparam int CW = $clog2(RSP_DEPTH) + 1;

    logic        a_vld_q, a_vld_d;
    logic [31:0] a_addr_q, a_addr_d;
    logic        a_write_q, a_write_d;
    logic [2:0]  a_size_q, a_size_d;
    logic [3:0]  a_prot_q, a_prot_d;
    logic [63:0] a_wdata_q, a_wdata_d;
    logic        d_vld_q, d_vld_d;
    logic        d_write_q, d_write_d;
    logic [63:0] d_wdata_q, d_wdata_d;
    logic [CW-1:0] inflight_q, inflight_d;

    logic          accept, push, pop;
    ahb_rsp_t      push_rsp, head_rsp;
    logic [CW-1:0] fifo_count;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            a_vld_q    <= 1'b0;
            a_addr_q   <= '0;
            a_write_q  <= 1'b0;
            a_size_q   <= '0;
            a_prot_q   <= '0;
            a_wdata_q  <= '0;
            d_vld_q    <= 1'b0;
            d_write_q  <= 1'b0;
            d_wdata_q  <= '0;
            inflight_q <= '0;
        end else begin
            a_vld_q    <= a_vld_d;
            a_addr_q   <= a_addr_d;
            a_write_q  <= a_write_d;
            a_size_q   <= a_size_d;
            a_prot_q   <= a_prot_d;
            a_wdata_q  <= a_wdata_d;
            d_vld_q    <= d_vld_d;
            d_write_q  <= d_write_d;
            d_wdata_q  <= d_wdata_d;
            inflight_q <= inflight_d;
        end
    end

    // Credit covers A, D and every FIFO entry, so a completing data phase always finds a slot.
    assign pop       = rsp_valid & rsp_ready;
    assign req_ready = ~HRESET & (~a_vld_q | HREADY) & ((inflight_q < CW'(RSP_DEPTH)) | pop);
    assign accept    = req_valid & req_ready;
    assign push      = HREADY & d_vld_q;

    always_comb begin
        a_vld_d   = a_vld_q;
        a_addr_d  = a_addr_q;
        a_write_d = a_write_q;
        a_size_d  = a_size_q;
        a_prot_d  = a_prot_q;
        a_wdata_d = a_wdata_q;
        d_vld_d   = d_vld_q;
        d_write_d = d_write_q;
        d_wdata_d = d_wdata_q;
        if (HREADY) begin
            d_vld_d = a_vld_q;
            if (a_vld_q) begin
                d_write_d = a_write_q;
                d_wdata_d = a_wdata_q;
            end
            a_vld_d = 1'b0;
        end
        // Address fields only change on accept so HADDR etc. hold while idle.
        if (accept) begin
            a_vld_d   = 1'b1;
            a_addr_d  = req_addr;
            a_write_d = req_write;
            a_size_d  = req_size;
            a_prot_d  = req_prot;
            a_wdata_d = req_wdata;
        end
        inflight_d = inflight_q + CW'(accept) - CW'(pop);
    end

    always_comb begin
        push_rsp.write = d_write_q;
        push_rsp.rdata = d_write_q ? 64'h0 : HRDATA;
        push_rsp.err   = HRESP;
    end

    ahb_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk       (HCLK),
        .rst       (HRESET),
        .push      (push),
        .push_data (push_rsp),
        .pop       (pop),
        .head_data (head_rsp),
        .count     (fifo_count)
    );

    assign rsp_valid = (fifo_count != '0);
    assign rsp_write = rsp_valid & head_rsp.write;
    assign rsp_rdata = rsp_valid ? head_rsp.rdata : 64'h0;
    assign rsp_err   = rsp_valid & head_rsp.err;

    assign HTRANS = a_vld_q ? NONSEQ : IDLE;
    assign HBURST = HBURST_SINGLE;
    assign HSEL   = 1'b1;
    assign HADDR  = a_addr_q;
    assign HWRITE = a_write_q;
    assign HSIZE  = a_size_q;
    assign HPROT  = a_prot_q;
    assign HWDATA = d_wdata_q;

    assert property (@(posedge HCLK) disable iff (HRESET)
        accept |-> (req_size <= 3'd3 && addr_aligned(req_addr, req_size)));

endmodule

// File: tb/tb_ahb_lite_req_master.sv
// Directed bench for ahb_lite_req_master against a small behavioural AHB memory slave.
module tb_ahb_lite_req_master;
    import ahb_tb_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [2:0]  req_size = '0;
    logic [3:0]  req_prot = '0;
    logic [63:0] req_wdata = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_write, rsp_err;
    logic [63:0] rsp_rdata;
    logic [31:0] HADDR;
    logic        HWRITE, HSEL, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic [63:0] HWDATA, HRDATA;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int dws      = 0;

    ahb_lite_req_master #(.RSP_DEPTH(4)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_prot(req_prot), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HPROT(HPROT), .HTRANS(HTRANS),
        .HBURST(HBURST), .HWDATA(HWDATA), .HSEL(HSEL),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;

    // Memory slave: dws wait states per transfer, inverted read data while waiting,
    // error response for addresses in 0xF000..0xFFFF.
    logic [63:0] mem [8192];
    logic        dp_act, dp_write;
    logic [31:0] dp_addr;
    logic [2:0]  dp_size;
    int          dp_wait;
    logic [63:0] mem_rd;

    assign mem_rd = mem[dp_addr[15:3]];
    assign HREADY = !dp_act || dp_wait == 0;
    assign HRESP  = dp_act && dp_wait == 0 && dp_addr[15:12] == 4'hF;
    assign HRDATA = (dp_act && !dp_write) ? ((dp_wait == 0) ? mem_rd : ~mem_rd) : 64'h0;

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                          input logic [2:0] off, input logic [2:0] sz);
        logic [63:0] r;
        int nb;
        r  = old;
        nb = 1 << sz;
        for (int i = 0; i < 8; i++)
            if (i >= int'(off) && i < int'(off) + nb) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    always @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dp_act <= 1'b0; dp_write <= 1'b0; dp_addr <= '0; dp_size <= '0; dp_wait <= 0;
        end else if (dp_act && dp_wait != 0) begin
            dp_wait <= dp_wait - 1;
        end else begin
            if (dp_act && dp_write && !HRESP)
                mem[dp_addr[15:3]] <= merge(mem_rd, HWDATA, dp_addr[2:0], dp_size);
            dp_act   <= HSEL && HTRANS[1];
            dp_addr  <= HADDR;
            dp_write <= HWRITE;
            dp_size  <= HSIZE;
            dp_wait  <= dws;
        end
    end

    typedef struct { logic write; logic [63:0] rdata; logic err; int cyc; } rsp_rec_t;
    typedef struct { logic [31:0] addr; logic write; logic [2:0] size; logic [3:0] prot; int cyc; } ap_rec_t;
    rsp_rec_t rsp_q[$];
    ap_rec_t  ap_q[$];
    int       acc_q[$];

    // Monitors sample at the falling edge; acc_q holds the edge number that accepts.
    always @(negedge HCLK) begin
        rsp_rec_t r;
        ap_rec_t  a;
        if (!HRESET) begin
            if (rsp_valid && rsp_ready) begin
                r.write = rsp_write; r.rdata = rsp_rdata; r.err = rsp_err; r.cyc = cyc;
                rsp_q.push_back(r);
            end
            if (req_valid && req_ready) acc_q.push_back(cyc + 1);
            if (HTRANS == 2'b10 && HREADY) begin
                a.addr = HADDR; a.write = HWRITE; a.size = HSIZE; a.prot = HPROT; a.cyc = cyc;
                ap_q.push_back(a);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge HCLK);
        #2;
    endtask

    task automatic clear_queues();
        rsp_q.delete(); ap_q.delete(); acc_q.delete();
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [2:0] sz,
                         input logic [3:0] pr, input logic [63:0] wd);
        bit done;
        done = 0;
        req_valid = 1'b1; req_write = w; req_addr = a; req_size = sz; req_prot = pr; req_wdata = wd;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge HCLK);
            if (req_ready) begin
                @(posedge HCLK);
                #2;
                done = 1;
            end
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL issue_accept addr=%h: accepted=0 required=1", a);
            req_valid = 1'b0;
        end
    endtask

    task automatic wait_rsp(input int n);
        for (int i = 0; i < 100 && rsp_q.size() < n; i++) step(1);
        step(2);
        n_checks++;
        if (rsp_q.size() !== n) begin
            n_fail++;
            $display("FAIL rsp_count: got %0d required %0d", rsp_q.size(), n);
        end
    endtask

    task automatic test_reset();
        int bad;
        @(posedge HCLK); #2;
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b required 0", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid); end
        n_checks++; if ({rsp_write, rsp_err, rsp_rdata} !== 66'h0) begin n_fail++; $display("FAIL rst_rsp_fields: got %b %b %h required 0", rsp_write, rsp_err, rsp_rdata); end
        n_checks++; if (HTRANS !== 2'b00) begin n_fail++; $display("FAIL rst_htrans: got %b required 00", HTRANS); end
        n_checks++; if (HADDR !== 32'h0) begin n_fail++; $display("FAIL rst_haddr: got %h required 0", HADDR); end
        n_checks++; if ({HWRITE, HSIZE, HPROT} !== 8'h0) begin n_fail++; $display("FAIL rst_hctl: got %b %b %b required 0", HWRITE, HSIZE, HPROT); end
        n_checks++; if (HWDATA !== 64'h0) begin n_fail++; $display("FAIL rst_hwdata: got %h required 0", HWDATA); end
        n_checks++; if (HBURST !== 3'b000) begin n_fail++; $display("FAIL rst_hburst: got %b required 000", HBURST); end
        n_checks++; if (HSEL !== 1'b1) begin n_fail++; $display("FAIL rst_hsel: got %b required 1", HSEL); end
        HRESET = 1'b0;
        step(1);
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rel_req_ready: got %b required 1", req_ready); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (HTRANS !== 2'b00 || HSEL !== 1'b1) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL idle_bus: %0d non-idle cycles, required 0", bad); end
    endtask

    task automatic test_write_read();
        clear_queues();
        dws = 0; rsp_ready = 1'b1;
        issue(1'b1, 32'h1000, 3'd3, 4'b0011, 64'h1122334455667788);
        issue(1'b0, 32'h1000, 3'd3, 4'b0001, 64'h0);
        req_valid = 1'b0;
        n_checks++; if (HWDATA !== 64'h1122334455667788) begin n_fail++; $display("FAIL wr_hwdata: got %h required 1122334455667788", HWDATA); end
        wait_rsp(2);
        if (rsp_q.size() == 2 && ap_q.size() == 2 && acc_q.size() == 2) begin
            n_checks++; if (ap_q[0].addr !== 32'h1000 || ap_q[0].write !== 1'b1 || ap_q[0].size !== 3'd3 || ap_q[0].prot !== 4'b0011) begin
                n_fail++; $display("FAIL wr_addr_phase: got %h %b %0d %b required 1000 1 3 0011", ap_q[0].addr, ap_q[0].write, ap_q[0].size, ap_q[0].prot); end
            n_checks++; if (ap_q[1].write !== 1'b0 || ap_q[1].prot !== 4'b0001) begin
                n_fail++; $display("FAIL rd_addr_phase: got write=%b prot=%b required 0 0001", ap_q[1].write, ap_q[1].prot); end
            n_checks++; if (rsp_q[0].write !== 1'b1 || rsp_q[0].rdata !== 64'h0 || rsp_q[0].err !== 1'b0) begin
                n_fail++; $display("FAIL wr_rsp: got %b %h %b required 1 0 0", rsp_q[0].write, rsp_q[0].rdata, rsp_q[0].err); end
            n_checks++; if (rsp_q[1].write !== 1'b0 || rsp_q[1].rdata !== 64'h1122334455667788 || rsp_q[1].err !== 1'b0) begin
                n_fail++; $display("FAIL rd_rsp: got %b %h %b required 0 1122334455667788 0", rsp_q[1].write, rsp_q[1].rdata, rsp_q[1].err); end
            n_checks++; if (rsp_q[1].cyc - acc_q[1] !== 2) begin
                n_fail++; $display("FAIL rd_latency: got %0d required 2", rsp_q[1].cyc - acc_q[1]); end
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        clear_queues();
        for (int i = 0; i < 8; i++)
            issue(1'b1, 32'h2000 + i, 3'd0, 4'b0001, (64'hA0 + 64'(i)) << (8 * i));
        issue(1'b0, 32'h2000, 3'd3, 4'b0001, 64'h0);
        req_valid = 1'b0;
        wait_rsp(9);
        bad = 0;
        for (int i = 0; i < 8 && ap_q.size() >= 8; i++)
            if (ap_q[i].cyc !== ap_q[0].cyc + i || ap_q[i].addr !== 32'h2000 + i) bad++;
        n_checks++; if (ap_q.size() < 8 || bad !== 0) begin n_fail++; $display("FAIL b2b_nonseq: %0d bad of %0d phases, required 0 bad of 9", bad, ap_q.size()); end
        if (rsp_q.size() == 9) begin
            n_checks++; if (rsp_q[8].rdata !== 64'hA7A6A5A4A3A2A1A0) begin
                n_fail++; $display("FAIL b2b_read: got %h required a7a6a5a4a3a2a1a0", rsp_q[8].rdata); end
        end
    endtask

    task automatic test_wait_states();
        clear_queues();
        dws = 3;
        issue(1'b0, 32'h1000, 3'd3, 4'b0001, 64'h0);
        issue(1'b0, 32'h2000, 3'd3, 4'b0001, 64'h0);
        req_valid = 1'b0;
        wait_rsp(2);
        if (rsp_q.size() == 2 && acc_q.size() == 2) begin
            n_checks++; if (rsp_q[0].rdata !== 64'h1122334455667788) begin
                n_fail++; $display("FAIL ws_rdata0: got %h required 1122334455667788", rsp_q[0].rdata); end
            n_checks++; if (rsp_q[1].rdata !== 64'hA7A6A5A4A3A2A1A0) begin
                n_fail++; $display("FAIL ws_rdata1: got %h required a7a6a5a4a3a2a1a0", rsp_q[1].rdata); end
            n_checks++; if (rsp_q[0].cyc - acc_q[0] !== 5) begin
                n_fail++; $display("FAIL ws_latency: got %0d required 5", rsp_q[0].cyc - acc_q[0]); end
            n_checks++; if (rsp_q[1].cyc - rsp_q[0].cyc !== 4) begin
                n_fail++; $display("FAIL ws_second_gap: got %0d required 4", rsp_q[1].cyc - rsp_q[0].cyc); end
        end
        dws = 0;
    endtask

    task automatic test_backpressure();
        int bad;
        clear_queues();
        rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) issue(1'b0, 32'h3000 + 8 * k, 3'd3, 4'b0001, 64'h0);
        req_valid = 1'b1; req_addr = 32'h3020;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (req_ready !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0 || acc_q.size() !== 4) begin n_fail++; $display("FAIL bp_stall: accepted %0d ready-cycles %0d, required 4 and 0", acc_q.size(), bad); end
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_rsp_valid: got %b required 1", rsp_valid); end
        rsp_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_pop_ready: got %b required 1", req_ready); end
        step(1);
        rsp_ready = 1'b0;
        n_checks++; if (acc_q.size() !== 5) begin n_fail++; $display("FAIL bp_accept5: got %0d required 5", acc_q.size()); end
        rsp_ready = 1'b1;
        issue(1'b0, 32'h3028, 3'd3, 4'b0001, 64'h0);
        req_valid = 1'b0;
        wait_rsp(6);
        for (int k = 0; k < 6 && rsp_q.size() == 6; k++) begin
            n_checks++;
            if (rsp_q[k].rdata !== (64'hFACE000000000000 | (64'h600 + 64'(k)))) begin
                n_fail++; $display("FAIL bp_order[%0d]: got %h required %h", k, rsp_q[k].rdata, 64'hFACE000000000000 | (64'h600 + 64'(k)));
            end
        end
    endtask

    task automatic test_error();
        clear_queues();
        issue(1'b0, 32'hF000, 3'd3, 4'b0001, 64'h0);
        issue(1'b0, 32'h1000, 3'd3, 4'b0001, 64'h0);
        req_valid = 1'b0;
        wait_rsp(2);
        if (rsp_q.size() == 2) begin
            n_checks++; if (rsp_q[0].err !== 1'b1) begin n_fail++; $display("FAIL err_flag: got %b required 1", rsp_q[0].err); end
            n_checks++; if (rsp_q[1].err !== 1'b0 || rsp_q[1].rdata !== 64'h1122334455667788 || rsp_q[1].cyc - rsp_q[0].cyc !== 1) begin
                n_fail++; $display("FAIL err_next: got err=%b %h gap=%0d required 0 1122334455667788 1", rsp_q[1].err, rsp_q[1].rdata, rsp_q[1].cyc - rsp_q[0].cyc); end
        end
    endtask

    task automatic test_reset_mid();
        clear_queues();
        issue(1'b1, 32'h4000, 3'd3, 4'b0001, 64'hDEADBEEFCAFEF00D);
        issue(1'b0, 32'h1000, 3'd3, 4'b0001, 64'h0);
        req_valid = 1'b0;
        n_checks++; if (HTRANS !== 2'b10 || HWDATA !== 64'hDEADBEEFCAFEF00D) begin
            n_fail++; $display("FAIL mid_inflight: got %b %h required 10 deadbeefcafef00d", HTRANS, HWDATA); end
        HRESET = 1'b1;
        #1;
        n_checks++; if (HTRANS !== 2'b00 || HADDR !== 32'h0 || HWDATA !== 64'h0) begin
            n_fail++; $display("FAIL mid_async: got %b %h %h required 00 0 0", HTRANS, HADDR, HWDATA); end
        n_checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_ctl: got ready=%b rsp_valid=%b required 0 0", req_ready, rsp_valid); end
        step(2);
        HRESET = 1'b0;
        clear_queues();
        step(6);
        n_checks++; if (rsp_q.size() !== 0) begin n_fail++; $display("FAIL mid_stale: got %0d responses required 0", rsp_q.size()); end
        issue(1'b0, 32'h1000, 3'd3, 4'b0001, 64'h0);
        req_valid = 1'b0;
        wait_rsp(1);
        if (rsp_q.size() == 1) begin
            n_checks++; if (rsp_q[0].rdata !== 64'h1122334455667788) begin
                n_fail++; $display("FAIL mid_read: got %h required 1122334455667788", rsp_q[0].rdata); end
        end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 64'hFACE000000000000 | 64'(i);
        test_reset();
        test_write_read();
        test_back_to_back();
        test_wait_states();
        test_backpressure();
        test_error();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ahb_lite_req_master.md
# ahb_lite_req_master

Testbench-side AHB-Lite master that turns a simple valid/ready request stream into single AHB-Lite transfers and returns in-order responses. It drives the AHB slave memory model (`ahb_sif`) directly, single master, single slave, no interconnect. Transfers are pipelined: the next address phase overlaps the current data phase. A response FIFO with credit-based issue guarantees every completed data phase has a slot.

## Interface
Parameters:
- `RSP_DEPTH`, 4: response FIFO entries and the max in-flight credit count (power of two, ≥2).

Ports:
- `HCLK` in 1: clock, all state on rising edge.
- `HRESET` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request offered.
- `req_ready` out 1: request accepted when `req_valid & req_ready`.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in 32: byte address, aligned to `req_size` (caller obligation, asserted in simulation).
- `req_size` in 3: AHB HSIZE encoding, 0..3 only.
- `req_prot` in 4: passed to HPROT; bit0 = data (1) or instruction (0).
- `req_wdata` in 64: write data, lane-aligned as on the bus.
- `rsp_valid` out 1: response available at FIFO head.
- `rsp_ready` in 1: response consumed when `rsp_valid & rsp_ready`.
- `rsp_write` out 1: echoes `req_write`.
- `rsp_rdata` out 64: captured HRDATA; 0 for writes.
- `rsp_err` out 1: HRESP was 1 at completion.
- `HADDR`, `HWRITE`, `HSIZE` (3), `HPROT` (4), `HTRANS` (2), `HBURST` (3), `HWDATA` (64), `HSEL` out: AHB master outputs.
- `HREADY` in 1: slave HREADYOUT, also fed to the slave's HREADY.
- `HRESP` in 1, `HRDATA` in 64: slave outputs.

## Operation
- Two pipeline registers. Address register A (valid, addr, write, size, prot, wdata) drives the bus address phase. Data register D (valid, write, wdata) drives the data phase.
- `HTRANS` = NONSEQ (2'b10) when A valid, else IDLE (2'b00).
- `HBURST` is constant SINGLE (3'b000).
- `HSEL` is constant 1. Idle cycles are expressed only through HTRANS=IDLE, because the slave holds its latched write flag while HSEL is low.
- `HADDR`, `HWRITE`, `HSIZE`, `HPROT` come from A. They hold their last values when A is invalid.
- `HWDATA` comes from D.wdata.
- Advance on `HREADY=1`:
  - D completes: push {D.write, D.write ? 0 : HRDATA, HRESP} into the FIFO.
  - A moves to D, or D clears if A is invalid.
  - If a request is accepted, it loads A; otherwise A clears.
- On `HREADY=0`, A and D hold. HRDATA is ignored, since the slave presents inverted data during wait states.
- Credit counter `inflight` = A.valid + D.valid + FIFO count, range 0..RSP_DEPTH.
  - Increments on accept, decrements on pop; both in the same cycle leaves it unchanged.
- `req_ready = (~A.valid | HREADY) & (inflight < RSP_DEPTH | pop)`.
  - The FIFO can never overflow. An overflow is an assertion failure.
- Responses come out strictly in request order.
- An error response (`HRESP=1` with `HREADY=1`) is reported and does not cancel the following address phase.
- Reset, including mid-transfer: A, D and the FIFO are cleared and `inflight`=0. In-flight transfers are dropped with no response.

## Timing
- Reset values:
  - `req_ready`=0 while HRESET is asserted, and 1 the first cycle after release.
  - `rsp_valid`=0, `rsp_*`=0.
  - `HTRANS`=IDLE, `HADDR`=0, `HWRITE`=0, `HSIZE`=0, `HPROT`=0, `HWDATA`=0, `HBURST`=0, `HSEL`=1.
- Request accepted at edge N:
  - Address phase is in cycle N+1.
  - Data phase is in cycle N+2 with zero wait states; `HWDATA` is valid throughout it.
  - `rsp_valid` rises at N+3.
- Each slave wait state adds one cycle to the completion of that transfer, and stalls the following address phase for that cycle.
- Throughput is one transfer per cycle with zero wait states, `rsp_ready`=1 and RSP_DEPTH≥3.
- With `rsp_ready`=0, exactly RSP_DEPTH requests are accepted, then `req_ready` stays low until a pop.
- No combinational path from `req_*` to any `H*` output. `req_ready` depends combinationally on `HREADY` and `rsp_ready`.

## Structure
- Package `ahb_tb_pkg`:
  - `htrans_e` (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
  - `hsize_e`.
  - HBURST_SINGLE constant.
  - `ahb_rsp_t` struct {write, rdata[63:0], err}.
- Sub-module `ahb_rsp_fifo`:
  - Parameterised depth, holds `ahb_rsp_t`.
  - push/pop/count interface, first-word-fall-through.
  - Same clock and asynchronous active-high reset.
- The top-level module holds the A/D registers, credit counter and bus drive.

## Test plan
- Reset release: check all reset values. With no requests, 20 cycles of HTRANS=IDLE and HSEL=1.
- Single write then read, zero wait states, `rsp_ready`=1:
  - Requests: write addr 0x1000 size 3 data 0x1122334455667788, then read addr 0x1000.
  - Read response at N+3 after its accept, rdata 0x1122334455667788, `rsp_err`=0.
- Back-to-back byte writes to 0x2000..0x2007 (size 0, one byte each in lane i), then one size-3 read:
  - Eight consecutive NONSEQ cycles.
  - Read returns the assembled 64-bit value.
- Slave wait states (dws=3): read during wait states.
  - No response while HREADY=0 (inverted HRDATA never captured).
  - Response arrives 3 cycles later than the zero-wait case with correct data.
- Back-pressure with `rsp_ready`=0 and 6 pending requests:
  - Exactly 4 accepted, `req_ready` then low.
  - After one pop, `req_ready` returns the same cycle.
  - All 6 responses arrive in order.
- HRESET asserted while one transfer is in the data phase and one is in the address phase:
  - Outputs return to reset values immediately (asynchronous).
  - No stale response after release.
  - A subsequent read returns correct memory contents.
